// File: rtl/axonerve_kvs_kernel_if.sv
`default_nettype none
// ============================================================================
// axonerve_kvs_kernel_if : host <-> kernel command / result bundle
// Revision: 1.0
// ============================================================================
interface axonerve_kvs_kernel_if;
  logic [31:0]  O_VERSION;
  logic         O_READY;
  logic         O_WAIT;
  logic         O_ACK;
  logic         O_ENT_ERR;
  logic         O_SINGLE_HIT;
  logic         O_MULTI_HIT;
  logic [127:0] O_KEY_DAT;
  logic [127:0] O_EKEY_MSK;
  logic [6:0]   O_KEY_PRI;
  logic [31:0]  O_KEY_VALUE;
  logic         O_CMD_EMPTY;
  logic         O_CMD_FULL;
  logic         O_ENT_FULL;
  logic [31:0]  O_KERNEL_STATUS;
  logic         I_CMD_INIT;
  logic         I_CMD_VALID;
  logic         I_CMD_ERASE;
  logic         I_CMD_WRITE;
  logic         I_CMD_READ;
  logic         I_CMD_SEARCH;
  logic         I_CMD_UPDATE;
  logic [127:0] I_KEY_DAT;
  logic [127:0] I_EKEY_MSK;
  logic [6:0]   I_KEY_PRI;
  logic [31:0]  I_KEY_VALUE;

  modport master (
    input  O_VERSION, O_READY, O_WAIT, O_ACK, O_ENT_ERR, O_SINGLE_HIT, O_MULTI_HIT,
           O_KEY_DAT, O_EKEY_MSK, O_KEY_PRI, O_KEY_VALUE, O_CMD_EMPTY, O_CMD_FULL,
           O_ENT_FULL, O_KERNEL_STATUS,
    output I_CMD_INIT, I_CMD_VALID, I_CMD_ERASE, I_CMD_WRITE, I_CMD_READ, I_CMD_SEARCH,
           I_CMD_UPDATE, I_KEY_DAT, I_EKEY_MSK, I_KEY_PRI, I_KEY_VALUE
  );

  modport slave (
    output O_VERSION, O_READY, O_WAIT, O_ACK, O_ENT_ERR, O_SINGLE_HIT, O_MULTI_HIT,
           O_KEY_DAT, O_EKEY_MSK, O_KEY_PRI, O_KEY_VALUE, O_CMD_EMPTY, O_CMD_FULL,
           O_ENT_FULL, O_KERNEL_STATUS,
    input  I_CMD_INIT, I_CMD_VALID, I_CMD_ERASE, I_CMD_WRITE, I_CMD_READ, I_CMD_SEARCH,
           I_CMD_UPDATE, I_KEY_DAT, I_EKEY_MSK, I_KEY_PRI, I_KEY_VALUE
  );
endinterface
`default_nettype wire

// File: rtl/axonerve_kvs_kernel.sv
`default_nettype none
// ============================================================================
// axonerve_kvs_kernel : ternary-key key/value store with queued command execution
// Revision: 1.0
// ============================================================================
module axonerve_kvs_kernel #(
  parameter int          DEPTH      = 16,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] VERSION    = 32'h0001_0000
) (
  input  logic                 I_CLK,
  input  logic                 I_RST,
  axonerve_kvs_kernel_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int FAW = $clog2(FIFO_DEPTH);

  localparam logic [0:0]    ST_SWEEP  = 1'b0;
  localparam logic [0:0]    ST_RUN    = 1'b1;
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] IDX_ONE   = AW'(1);
  localparam logic [FAW-1:0] PTR_ONE  = FAW'(1);
  localparam logic [FAW:0]  FCNT_ONE  = (FAW + 1)'(1);
  localparam logic [FAW:0]  FCNT_FULL = (FAW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   HCNT_ONE  = (AW + 1)'(1);

  typedef struct packed {
    logic [4:0]   op;     // {erase, write, read, search, update}
    logic [127:0] key;
    logic [127:0] mask;
    logic [6:0]   pri;
    logic [31:0]  value;
  } cmd_t;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] sweep_idx_q, sweep_idx_d;
  logic          ready;

  cmd_t           fifo_mem_q [FIFO_DEPTH];
  logic [FAW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FAW:0]   fifo_cnt_q, fifo_cnt_d;
  logic           fifo_empty, fifo_full, push, pop;
  cmd_t           push_cmd;

  logic ex_vld_q, ex_vld_d;
  cmd_t ex_cmd_q, ex_cmd_d;

  logic [DEPTH-1:0] ent_valid_q, ent_valid_d;
  logic [127:0]     ent_key_q  [DEPTH];
  logic [127:0]     ent_key_d  [DEPTH];
  logic [127:0]     ent_mask_q [DEPTH];
  logic [127:0]     ent_mask_d [DEPTH];
  logic [6:0]       ent_pri_q  [DEPTH];
  logic [6:0]       ent_pri_d  [DEPTH];
  logic [31:0]      ent_val_q  [DEPTH];
  logic [31:0]      ent_val_d  [DEPTH];

  logic         ack_q, ack_d, err_q, err_d, single_q, single_d, multi_q, multi_d;
  logic [127:0] rkey_q, rkey_d, rmask_q, rmask_d;
  logic [6:0]   rpri_q, rpri_d;
  logic [31:0]  rval_q, rval_d;

  logic [AW:0] vcnt, vcnt_q;
  logic        ent_full_q;

  logic [DEPTH-1:0] match, exact;
  logic [AW:0]      hit_cnt;
  logic             win_found, exact_found, free_found;
  logic [AW-1:0]    win_idx, exact_idx, free_idx, rd_addr;
  logic [6:0]       win_pri;
  logic             do_insert;

  // ---------------- init sweep ----------------
  assign ready = (state_q == ST_RUN);

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    if (bus.I_CMD_INIT) begin
      state_d     = ST_SWEEP;
      sweep_idx_d = '0;
    end else if (state_q == ST_SWEEP) begin
      sweep_idx_d = sweep_idx_q + IDX_ONE;
      if (sweep_idx_q == LAST_IDX) state_d = ST_RUN;
    end
  end

  // ---------------- command FIFO ----------------
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == FCNT_FULL);
  assign pop        = ready & ~fifo_empty & ~bus.I_CMD_INIT;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push       = bus.I_CMD_VALID & ready & (~fifo_full | pop) & ~bus.I_CMD_INIT;

  assign push_cmd.op    = {bus.I_CMD_ERASE, bus.I_CMD_WRITE, bus.I_CMD_READ,
                           bus.I_CMD_SEARCH, bus.I_CMD_UPDATE};
  assign push_cmd.key   = bus.I_KEY_DAT;
  assign push_cmd.mask  = bus.I_EKEY_MSK;
  assign push_cmd.pri   = bus.I_KEY_PRI;
  assign push_cmd.value = bus.I_KEY_VALUE;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    ex_vld_d   = pop;
    ex_cmd_d   = ex_cmd_q;
    if (bus.I_CMD_INIT) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        ex_cmd_d = fifo_mem_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   fifo_cnt_d = fifo_cnt_q + FCNT_ONE;
        2'b01:   fifo_cnt_d = fifo_cnt_q - FCNT_ONE;
        default: fifo_cnt_d = fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge I_CLK) begin
    if (push) fifo_mem_q[wr_ptr_q] <= push_cmd;
  end

  // ---------------- entry match ----------------
  always_comb begin
    match = '0;
    exact = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = ent_valid_q[i] & (((ent_key_q[i] ^ ex_cmd_q.key) & ~ent_mask_q[i]) == '0);
      exact[i] = ent_valid_q[i] & (ent_key_q[i] == ex_cmd_q.key) & (ent_mask_q[i] == ex_cmd_q.mask);
    end
  end

  // Winner is the lowest priority value; strict '<' keeps the lowest index on ties.
  always_comb begin
    hit_cnt     = '0;
    win_found   = 1'b0;
    win_idx     = '0;
    win_pri     = '0;
    exact_found = 1'b0;
    exact_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match[i]) begin
        hit_cnt = hit_cnt + HCNT_ONE;
        if (!win_found || (ent_pri_q[i] < win_pri)) begin
          win_found = 1'b1;
          win_idx   = AW'(i);
          win_pri   = ent_pri_q[i];
        end
      end
      if (exact[i] && !exact_found) begin
        exact_found = 1'b1;
        exact_idx   = AW'(i);
      end
      if (!ent_valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = AW'(i);
      end
    end
  end

  assign rd_addr = ex_cmd_q.value[AW-1:0];

  // ---------------- execute ----------------
  always_comb begin
    ent_valid_d = ent_valid_q;
    ent_key_d   = ent_key_q;
    ent_mask_d  = ent_mask_q;
    ent_pri_d   = ent_pri_q;
    ent_val_d   = ent_val_q;
    ack_d       = 1'b0;
    err_d       = err_q;
    single_d    = single_q;
    multi_d     = multi_q;
    rkey_d      = rkey_q;
    rmask_d     = rmask_q;
    rpri_d      = rpri_q;
    rval_d      = rval_q;
    do_insert   = 1'b0;

    if (state_q == ST_SWEEP) ent_valid_d[sweep_idx_q] = 1'b0;

    if (bus.I_CMD_INIT) begin
      err_d    = 1'b0;
      single_d = 1'b0;
      multi_d  = 1'b0;
      rkey_d   = '0;
      rmask_d  = '0;
      rpri_d   = '0;
      rval_d   = '0;
    end else if (ex_vld_q) begin
      ack_d    = 1'b1;
      err_d    = 1'b0;
      single_d = 1'b0;
      multi_d  = 1'b0;
      rkey_d   = ex_cmd_q.key;
      rmask_d  = ex_cmd_q.mask;
      rpri_d   = ex_cmd_q.pri;
      rval_d   = ex_cmd_q.value;
      if (ex_cmd_q.op[4]) begin
        if (exact_found) begin
          ent_valid_d[exact_idx] = 1'b0;
          single_d = 1'b1;
          rkey_d   = ent_key_q[exact_idx];
          rmask_d  = ent_mask_q[exact_idx];
          rpri_d   = ent_pri_q[exact_idx];
          rval_d   = ent_val_q[exact_idx];
        end else begin
          err_d = 1'b1;
        end
      end else if (ex_cmd_q.op[3]) begin
        do_insert = 1'b1;
      end else if (ex_cmd_q.op[2]) begin
        if (ent_valid_q[rd_addr]) begin
          single_d = 1'b1;
          rkey_d   = ent_key_q[rd_addr];
          rmask_d  = ent_mask_q[rd_addr];
          rpri_d   = ent_pri_q[rd_addr];
          rval_d   = ent_val_q[rd_addr];
        end else begin
          err_d   = 1'b1;
          rkey_d  = '0;
          rmask_d = '0;
          rpri_d  = '0;
          rval_d  = '0;
        end
      end else if (ex_cmd_q.op[1]) begin
        if (win_found) begin
          single_d = (hit_cnt == HCNT_ONE);
          multi_d  = (hit_cnt > HCNT_ONE);
          rkey_d   = ent_key_q[win_idx];
          rmask_d  = ent_mask_q[win_idx];
          rpri_d   = ent_pri_q[win_idx];
          rval_d   = ent_val_q[win_idx];
        end else begin
          rkey_d  = '0;
          rmask_d = '0;
          rpri_d  = '0;
          rval_d  = '0;
        end
      end else if (ex_cmd_q.op[0]) begin
        if (exact_found) begin
          ent_val_d[exact_idx] = ex_cmd_q.value;
          single_d = 1'b1;
          rpri_d   = ent_pri_q[exact_idx];
        end else begin
          do_insert = 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end

      // Insert paths report the command fields, which equal the stored entry.
      if (do_insert) begin
        if (exact_found) begin
          ent_pri_d[exact_idx] = ex_cmd_q.pri;
          ent_val_d[exact_idx] = ex_cmd_q.value;
        end else if (free_found) begin
          ent_valid_d[free_idx] = 1'b1;
          ent_key_d[free_idx]   = ex_cmd_q.key;
          ent_mask_d[free_idx]  = ex_cmd_q.mask;
          ent_pri_d[free_idx]   = ex_cmd_q.pri;
          ent_val_d[free_idx]   = ex_cmd_q.value;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    vcnt = '0;
    for (int i = 0; i < DEPTH; i++) vcnt = vcnt + {{AW{1'b0}}, ent_valid_q[i]};
  end

  // ---------------- registers ----------------
  always_ff @(posedge I_CLK) begin
    ent_key_q  <= ent_key_d;
    ent_mask_q <= ent_mask_d;
    ent_pri_q  <= ent_pri_d;
    ent_val_q  <= ent_val_d;
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q     <= ST_SWEEP;
      sweep_idx_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      ex_vld_q    <= 1'b0;
      ex_cmd_q    <= '0;
      ent_valid_q <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      single_q    <= 1'b0;
      multi_q     <= 1'b0;
      rkey_q      <= '0;
      rmask_q     <= '0;
      rpri_q      <= '0;
      rval_q      <= '0;
      vcnt_q      <= '0;
      ent_full_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      ex_vld_q    <= ex_vld_d;
      ex_cmd_q    <= ex_cmd_d;
      ent_valid_q <= ent_valid_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      single_q    <= single_d;
      multi_q     <= multi_d;
      rkey_q      <= rkey_d;
      rmask_q     <= rmask_d;
      rpri_q      <= rpri_d;
      rval_q      <= rval_d;
      vcnt_q      <= vcnt;
      ent_full_q  <= &ent_valid_q;
    end
  end

  // ---------------- outputs ----------------
  assign bus.O_VERSION       = VERSION;
  assign bus.O_READY         = ready;
  assign bus.O_WAIT          = ~ready | fifo_full;
  assign bus.O_ACK           = ack_q;
  assign bus.O_ENT_ERR       = err_q;
  assign bus.O_SINGLE_HIT    = single_q;
  assign bus.O_MULTI_HIT     = multi_q;
  assign bus.O_KEY_DAT       = rkey_q;
  assign bus.O_EKEY_MSK      = rmask_q;
  assign bus.O_KEY_PRI       = rpri_q;
  assign bus.O_KEY_VALUE     = rval_q;
  assign bus.O_CMD_EMPTY     = fifo_empty;
  assign bus.O_CMD_FULL      = fifo_full;
  assign bus.O_ENT_FULL      = ent_full_q;
  assign bus.O_KERNEL_STATUS = {7'b0, ready, 8'(fifo_cnt_q), 16'(vcnt_q)};
endmodule
`default_nettype wire

// File: tb/tb_axonerve_kvs_kernel.sv
`default_nettype none
// ============================================================================
// tb_axonerve_kvs_kernel : directed self-checking bench for axonerve_kvs_kernel
// Revision: 1.0
// ============================================================================
module tb_axonerve_kvs_kernel;
  localparam int DEPTH = 16;
  localparam logic [4:0] OP_ERASE  = 5'b10000;
  localparam logic [4:0] OP_WRITE  = 5'b01000;
  localparam logic [4:0] OP_READ   = 5'b00100;
  localparam logic [4:0] OP_SEARCH = 5'b00010;
  localparam logic [4:0] OP_UPDATE = 5'b00001;
  localparam logic [4:0] OP_NONE   = 5'b00000;
  localparam logic [127:0] K_ABAD = {4{32'habadcafe}};
  localparam logic [127:0] K_DEAD = {4{32'hdeadbeef}};
  localparam logic [127:0] M_ZERO = '0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  logic         r_err, r_single, r_multi;
  logic [127:0] r_key;
  logic [6:0]   r_pri;
  logic [31:0]  r_val;
  int           r_lat;

  int           ack_n, n_cyc, n_ack_sweep;
  logic         bb_err    [19];
  logic         bb_single [19];
  logic [31:0]  bb_val    [19];

  axonerve_kvs_kernel_if bus();

  axonerve_kvs_kernel #(.DEPTH(DEPTH), .FIFO_DEPTH(16), .VERSION(32'h0001_0000)) dut (
    .I_CLK(clk),
    .I_RST(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [4:0] op, input logic [127:0] key, input logic [127:0] msk,
                       input logic [6:0] pri, input logic [31:0] val);
    bus.I_CMD_VALID = 1'b1;
    {bus.I_CMD_ERASE, bus.I_CMD_WRITE, bus.I_CMD_READ, bus.I_CMD_SEARCH, bus.I_CMD_UPDATE} = op;
    bus.I_KEY_DAT   = key;
    bus.I_EKEY_MSK  = msk;
    bus.I_KEY_PRI   = pri;
    bus.I_KEY_VALUE = val;
  endtask

  // One command, then wait (bounded) for its ACK and capture the result.
  task automatic cmd(input string tag, input logic [4:0] op, input logic [127:0] key,
                     input logic [127:0] msk, input logic [6:0] pri, input logic [31:0] val);
    @(negedge clk);
    drive(op, key, msk, pri, val);
    @(negedge clk);
    bus.I_CMD_VALID = 1'b0;
    r_lat = 0;
    while (r_lat < 20) begin
      @(negedge clk);
      r_lat++;
      if (bus.O_ACK) break;
    end
    chk({tag, "_ack"}, bus.O_ACK, 1'b1);
    r_err = bus.O_ENT_ERR; r_single = bus.O_SINGLE_HIT; r_multi = bus.O_MULTI_HIT;
    r_key = bus.O_KEY_DAT; r_pri = bus.O_KEY_PRI; r_val = bus.O_KEY_VALUE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus.I_CMD_INIT = 1'b0;
    drive(OP_NONE, '0, '0, '0, '0);
    bus.I_CMD_VALID = 1'b0;

    // Reset state
    repeat (10) @(negedge clk);
    chk("rst_ready",   bus.O_READY, 1'b0);
    chk("rst_wait",    bus.O_WAIT, 1'b1);
    chk("rst_empty",   bus.O_CMD_EMPTY, 1'b1);
    chk("rst_version", bus.O_VERSION, 32'h0001_0000);
    chk("rst_ack",     bus.O_ACK, 1'b0);
    chk("rst_status",  bus.O_KERNEL_STATUS, 32'h0);
    rst = 1'b0;
    n_cyc = 0;
    while (n_cyc < 100) begin
      @(negedge clk);
      n_cyc++;
      if (bus.O_READY) break;
    end
    chk("sweep_len", n_cyc, DEPTH);
    chk("ready_wait", bus.O_WAIT, 1'b0);

    // Basic write / search
    cmd("w_abad", OP_WRITE, K_ABAD, M_ZERO, 7'd0, 32'h34343434);
    chk("w_abad_lat", r_lat, 2);
    chk("w_abad_err", r_err, 1'b0);
    cmd("s_abad", OP_SEARCH, K_ABAD, M_ZERO, 7'd0, 32'h0);
    chk("s_abad_single", r_single, 1'b1);
    chk("s_abad_val", r_val, 32'h34343434);
    chk("s_abad_err", r_err, 1'b0);

    // Update existing entry
    cmd("w_dead", OP_WRITE, K_DEAD, M_ZERO, 7'd0, 32'ha5a5a5a5);
    cmd("u_abad", OP_UPDATE, K_ABAD, M_ZERO, 7'd0, 32'hfefefefe);
    chk("u_abad_single", r_single, 1'b1);
    cmd("s_abad2", OP_SEARCH, K_ABAD, M_ZERO, 7'd0, 32'h0);
    chk("s_abad2_val", r_val, 32'hfefefefe);
    cmd("s_dead", OP_SEARCH, K_DEAD, M_ZERO, 7'd0, 32'h0);
    chk("s_dead_val", r_val, 32'ha5a5a5a5);

    // Erase paths
    cmd("e_abad", OP_ERASE, K_ABAD, M_ZERO, 7'd0, 32'h0);
    chk("e_abad_err", r_err, 1'b0);
    chk("e_abad_single", r_single, 1'b1);
    chk("e_abad_echo", r_val, 32'hfefefefe);
    cmd("e_zero", OP_ERASE, '0, M_ZERO, 7'd0, 32'h0);
    chk("e_zero_err", r_err, 1'b1);
    cmd("s_abad3", OP_SEARCH, K_ABAD, M_ZERO, 7'd0, 32'h0);
    chk("s_abad3_single", r_single, 1'b0);
    chk("s_abad3_multi", r_multi, 1'b0);
    chk("s_abad3_val", r_val, 32'h0);
    chk("s_abad3_err", r_err, 1'b0);
    cmd("e_dead1", OP_ERASE, K_DEAD, M_ZERO, 7'd0, 32'h0);
    chk("e_dead1_err", r_err, 1'b0);
    cmd("e_dead2", OP_ERASE, K_DEAD, M_ZERO, 7'd0, 32'h0);
    chk("e_dead2_err", r_err, 1'b1);

    // Update-as-insert, then update in place (dead lands in entry 0)
    cmd("u_dead1", OP_UPDATE, K_DEAD, M_ZERO, 7'd0, 32'h5a5a5a5a);
    chk("u_dead1_err", r_err, 1'b0);
    chk("u_dead1_single", r_single, 1'b0);
    cmd("s_dead1", OP_SEARCH, K_DEAD, M_ZERO, 7'd0, 32'h0);
    chk("s_dead1_val", r_val, 32'h5a5a5a5a);
    cmd("u_dead2", OP_UPDATE, K_DEAD, M_ZERO, 7'd0, 32'h6b6b6b6b);
    chk("u_dead2_single", r_single, 1'b1);
    cmd("s_dead2", OP_SEARCH, K_DEAD, M_ZERO, 7'd0, 32'h0);
    chk("s_dead2_val", r_val, 32'h6b6b6b6b);

    // Ternary entries: A(idx1) key0/mask ff pri5, B(idx2) key1 pri3, C(idx3) all-don't-care pri3
    cmd("w_a", OP_WRITE, 128'h0, 128'hff, 7'd5, 32'h11);
    cmd("w_b", OP_WRITE, 128'h1, M_ZERO, 7'd3, 32'h22);
    cmd("w_c", OP_WRITE, 128'h0, '1, 7'd3, 32'h33);
    cmd("s_one", OP_SEARCH, 128'h1, M_ZERO, 7'd0, 32'h0);
    chk("s_one_multi", r_multi, 1'b1);
    chk("s_one_single", r_single, 1'b0);
    chk("s_one_val", r_val, 32'h22);
    chk("s_one_pri", r_pri, 7'd3);
    chk("s_one_key", r_key, 128'h1);
    cmd("s_dead3", OP_SEARCH, K_DEAD, M_ZERO, 7'd0, 32'h0);
    chk("s_dead3_multi", r_multi, 1'b1);
    chk("s_dead3_val", r_val, 32'h6b6b6b6b);

    // Read by address
    cmd("r_2", OP_READ, '0, M_ZERO, 7'd0, 32'd2);
    chk("r_2_err", r_err, 1'b0);
    chk("r_2_val", r_val, 32'h22);
    chk("r_2_key", r_key, 128'h1);
    cmd("r_15", OP_READ, '0, M_ZERO, 7'd0, 32'd15);
    chk("r_15_err", r_err, 1'b1);
    chk("r_15_val", r_val, 32'h0);

    // No opcode, and opcode priority (ERASE beats SEARCH)
    cmd("nop", OP_NONE, 128'h9, M_ZERO, 7'd0, 32'h77);
    chk("nop_err", r_err, 1'b1);
    chk("nop_echo", r_val, 32'h77);
    cmd("prio", OP_ERASE | OP_SEARCH, 128'h1, M_ZERO, 7'd0, 32'h0);
    chk("prio_err", r_err, 1'b0);
    chk("prio_single", r_single, 1'b1);
    chk("prio_val", r_val, 32'h22);
    @(negedge clk);
    chk("status_3", bus.O_KERNEL_STATUS, 32'h0100_0003);
    chk("ent_full_0", bus.O_ENT_FULL, 1'b0);

    // INIT: sweep restarts, commands during sweep are dropped
    bus.I_CMD_INIT = 1'b1;
    @(negedge clk);
    bus.I_CMD_INIT = 1'b0;
    n_cyc = 0;
    n_ack_sweep = 0;
    while (n_cyc < 100) begin
      @(negedge clk);
      n_cyc++;
      if (bus.O_ACK) n_ack_sweep++;
      if (bus.O_READY) break;
      if (n_cyc <= 3) drive(OP_WRITE, 128'h5, M_ZERO, 7'd0, 32'h5);
      else bus.I_CMD_VALID = 1'b0;
    end
    chk("init_sweep_len", n_cyc, DEPTH);
    chk("init_no_ack", n_ack_sweep, 0);
    chk("init_val_zero", bus.O_KEY_VALUE, 32'h0);
    chk("init_status", bus.O_KERNEL_STATUS, 32'h0100_0000);

    // 19 back-to-back: 17 writes (last one finds the table full), then 2 searches
    ack_n = 0;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      if (bus.O_ACK) begin
        if (ack_n < 19) begin
          bb_err[ack_n]    = bus.O_ENT_ERR;
          bb_single[ack_n] = bus.O_SINGLE_HIT;
          bb_val[ack_n]    = bus.O_KEY_VALUE;
        end
        ack_n++;
      end
      if (c < 17)       drive(OP_WRITE, 128'(c + 1), M_ZERO, 7'd0, 32'h100 + 32'(c));
      else if (c == 17) drive(OP_SEARCH, 128'h5, M_ZERO, 7'd0, 32'h0);
      else if (c == 18) drive(OP_SEARCH, 128'h11, M_ZERO, 7'd0, 32'h0);
      else              bus.I_CMD_VALID = 1'b0;
    end
    chk("bb_ack_count", ack_n, 19);
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("bb_w%0d_val", i), bb_val[i], 32'h100 + 32'(i));
      chk($sformatf("bb_w%0d_err", i), bb_err[i], (i == 16) ? 1'b1 : 1'b0);
    end
    chk("bb_s5_val", bb_val[17], 32'h104);
    chk("bb_s5_single", bb_single[17], 1'b1);
    chk("bb_s17_val", bb_val[18], 32'h0);
    chk("bb_s17_single", bb_single[18], 1'b0);
    chk("bb_s17_err", bb_err[18], 1'b0);
    chk("ent_full_1", bus.O_ENT_FULL, 1'b1);
    chk("status_full", bus.O_KERNEL_STATUS, 32'h0100_0010);
    chk("bb_empty", bus.O_CMD_EMPTY, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
